imem_loader: RTL and testbench

Boot-time program loader and access controller for the 256x8 instruction memory. Accepts a framed byte stream from the UART receiver: length byte, payload bytes, XOR checksum. Writes the payload into instruction memory from address 0 upward. Holds the CPU in reset while loading, then hands the memory address port back to the CPU fetch path.

---
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader / access controller for the 256x8 instruction memory.
// Latency: one cycle per accepted byte; CPU released the cycle after FIN.
// Backpressure: rx_ready high only in LEN/LOAD/CHECK; bytes offered in IDLE/FIN wait.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   start                 one-cycle load request (honoured only in IDLE)
//   rx_valid/rx_data      framed byte stream: length, payload, XOR checksum
//   rx_ready              loader can take a byte this cycle
//   cpu_pc                CPU fetch address, routed to memory when not busy
//   mem_addr/mem_w_data/mem_w_en   instruction memory port
//   cpu_reset             CPU/fetch reset (also read-zero reset of the memory)
//   busy, done, load_err  status: session active, success pulse, sticky error
//   bytes_loaded          payload bytes written in the current or last session
module imem_loader #(
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic [7:0] cpu_pc,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_w_data,
  output logic       mem_w_en,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       load_err,
  output logic [8:0] bytes_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CHECK,
    S_FIN
  } state_t;

  state_t     state;
  logic [7:0] ptr;
  logic [8:0] remaining;   // 9 bits so a length byte of 0x00 can stand for 256
  logic [7:0] acc;
  logic       hold;
  logic       xfer;

  assign xfer = rx_valid & rx_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= 8'd0;
      remaining    <= 9'd0;
      acc          <= 8'd0;
      bytes_loaded <= 9'd0;
      load_err     <= 1'b0;
      done         <= 1'b0;
      hold         <= BOOT_HOLD;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LEN;
            hold         <= 1'b1;
            load_err     <= 1'b0;
            bytes_loaded <= 9'd0;
            acc          <= 8'd0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            ptr       <= 8'd0;
            acc       <= rx_data;   // checksum covers the length byte too
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            ptr          <= ptr + 8'd1;
            remaining    <= remaining - 9'd1;
            acc          <= acc ^ rx_data;
            bytes_loaded <= bytes_loaded + 9'd1;
            if (remaining == 9'd1) begin
              state <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (rx_data == acc) begin
              state <= S_FIN;
              done  <= 1'b1;        // registered so it is high for the FIN cycle only
            end else begin
              load_err <= 1'b1;     // hold stays set: a bad image never runs
              state    <= S_IDLE;
            end
          end
        end
        S_FIN: begin
          hold  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign rx_ready   = (state == S_LEN) || (state == S_LOAD) || (state == S_CHECK);
  assign cpu_reset  = reset | hold | busy;
  assign mem_addr   = busy ? ptr : cpu_pc;
  assign mem_w_en   = (state == S_LOAD) && rx_valid;
  assign mem_w_data = (state == S_LOAD) ? rx_data : 8'd0;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic [7:0] cpu_pc = 8'h12;
  logic       rx_ready, mem_w_en, cpu_reset, busy, done, load_err;
  logic [7:0] mem_addr, mem_w_data;
  logic [8:0] bytes_loaded;

  // Second instance with BOOT_HOLD=0, inputs idle, only cpu_reset is checked.
  logic       b_rx_ready, b_mem_w_en, b_cpu_reset, b_busy, b_done, b_load_err;
  logic [7:0] b_mem_addr, b_mem_w_data;
  logic [8:0] b_bytes_loaded;

  always #5 clock = ~clock;

  imem_loader #(.BOOT_HOLD(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .cpu_pc(cpu_pc),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .load_err(load_err),
    .bytes_loaded(bytes_loaded)
  );

  imem_loader #(.BOOT_HOLD(1'b0)) dut_nohold (
    .clock(clock), .reset(reset), .start(1'b0), .rx_valid(1'b0),
    .rx_data(8'd0), .rx_ready(b_rx_ready), .cpu_pc(8'd0),
    .mem_addr(b_mem_addr), .mem_w_data(b_mem_w_data), .mem_w_en(b_mem_w_en),
    .cpu_reset(b_cpu_reset), .busy(b_busy), .done(b_done), .load_err(b_load_err),
    .bytes_loaded(b_bytes_loaded)
  );

  int ncmp = 0;
  int nfail = 0;
  int n_push = 0;
  int n_wr = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] pay[$];
  logic [7:0] tmem[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction memory model, written only through the DUT's memory port.
  always @(posedge clock) begin
    if (mem_w_en) tmem[mem_addr] <= mem_w_data;
  end

  // Scoreboard: every write seen on the memory port must match the next expected one.
  wr_t got;
  always @(negedge clock) begin
    if (mem_w_en) begin
      n_wr++;
      check("write_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        check("wr_addr", mem_addr, got.addr);
        check("wr_data", mem_w_data, got.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    forever begin
      @(negedge clock);
      if (rx_ready) begin
        @(posedge clock); #1;
        break;
      end
      n++;
      if (n > 100) begin
        check("rx_ready_timeout", 0, 1);
        break;
      end
      @(posedge clock); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  function automatic logic [7:0] good_chk();
    logic [7:0] c;
    c = 8'(pay.size());
    foreach (pay[i]) c ^= pay[i];
    return c;
  endfunction

  // Length byte, payload (scoreboarded), then the given checksum byte.
  task automatic stream(input logic [7:0] chk, input int max_gap, input bit poke);
    send(8'(pay.size()), 0);
    foreach (pay[i]) begin
      if (poke && i == 2) begin
        pulse_start();
        @(negedge clock);
        check("start_ignored_busy", busy, 1);
        check("start_ignored_count", bytes_loaded, 2);
        step();
      end
      exp_q.push_back('{addr: 8'(i), data: pay[i]});
      n_push++;
      send(pay[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    send(chk, 0);
  endtask

  task automatic readback();
    foreach (pay[i]) begin
      cpu_pc = 8'(i);
      @(negedge clock);
      check("rd_mem_addr", mem_addr, 8'(i));
      check("rd_data", tmem[mem_addr], pay[i]);
      step();
    end
  endtask

  initial begin
    // ---- reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_nohold_cpu_reset_in_reset", b_cpu_reset, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_cpu_reset", cpu_reset, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_mem_addr", mem_addr, 8'h12);
    check("post_rst_done", done, 0);
    check("post_rst_err", load_err, 0);
    check("post_rst_count", bytes_loaded, 0);
    check("nohold_cpu_reset", b_cpu_reset, 0);
    step();

    // ---- byte offered in IDLE is not consumed
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    @(negedge clock);
    check("idle_rx_ready", rx_ready, 0);
    step();
    @(negedge clock);
    check("idle_still_idle", busy, 0);
    step();
    rx_valid = 1'b0;

    // ---- good 3-byte load
    pay = '{8'hA1, 8'hB2, 8'hC3};
    check("chk_model", good_chk(), 8'hD3);
    pulse_start();
    stream(8'hD3, 0, 1'b0);
    @(negedge clock);
    check("s1_done", done, 1);
    check("s1_count", bytes_loaded, 3);
    check("s1_ptr", mem_addr, 8'h03);
    check("s1_cpu_reset_fin", cpu_reset, 1);
    step();
    @(negedge clock);
    check("s1_done_one_cycle", done, 0);
    check("s1_cpu_released", cpu_reset, 0);
    check("s1_busy", busy, 0);
    step();
    readback();

    // ---- same stream, bad checksum
    pulse_start();
    stream(8'h00, 0, 1'b0);
    @(negedge clock);
    check("s2_err", load_err, 1);
    check("s2_no_done", done, 0);
    check("s2_busy", busy, 0);
    check("s2_cpu_reset", cpu_reset, 1);
    step();
    @(negedge clock);
    check("s2_cpu_reset_held", cpu_reset, 1);
    check("s2_err_sticky", load_err, 1);
    step();

    // ---- new start clears error; 256-byte image with length byte 00
    pulse_start();
    @(negedge clock);
    check("s3_err_cleared", load_err, 0);
    check("s3_count_cleared", bytes_loaded, 0);
    check("s3_busy", busy, 1);
    step();
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'(i));
    check("s3_chk_model", good_chk(), 8'h00);
    stream(good_chk(), 0, 1'b0);
    @(negedge clock);
    check("s3_done", done, 1);
    check("s3_count", bytes_loaded, 256);
    check("s3_ptr_wrap", mem_addr, 8'h00);
    step();
    @(negedge clock);
    check("s3_released", cpu_reset, 0);
    step();
    cpu_pc = 8'hFF;
    @(negedge clock);
    check("s3_rd_ff", tmem[mem_addr], 8'hFF);
    step();
    cpu_pc = 8'h7F;
    @(negedge clock);
    check("s3_rd_7f", tmem[mem_addr], 8'h7F);
    step();

    // ---- random rx_valid gaps plus start mid-session
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'($urandom_range(0, 255)));
    pulse_start();
    stream(good_chk(), 3, 1'b1);
    @(negedge clock);
    check("s4_done", done, 1);
    check("s4_count", bytes_loaded, 5);
    check("s4_writes_eq_handshakes", n_wr, n_push);
    check("s4_queue_empty", exp_q.size(), 0);
    step();
    readback();

    // ---- reset after 2 of 5 payload bytes
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    pulse_start();
    send(8'd5, 0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{addr: 8'(i), data: pay[i]});
      n_push++;
      send(pay[i], 0);
    end
    @(negedge clock);
    check("s5_mid_count", bytes_loaded, 2);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_count", bytes_loaded, 0);
    check("s5_rst_cpu_reset", cpu_reset, 1);
    check("s5_rst_rx_ready", rx_ready, 0);
    step();
    pay = '{8'h9C, 8'h3E, 8'h07, 8'hF0};
    pulse_start();
    stream(good_chk(), 1, 1'b0);
    @(negedge clock);
    check("s5_done", done, 1);
    check("s5_count", bytes_loaded, 4);
    step();
    @(negedge clock);
    check("s5_released", cpu_reset, 0);
    check("s5_writes_eq_handshakes", n_wr, n_push);
    step();
    readback();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
